// File: rtl/char_buf_console_ctrl.sv
// Terminal-style write sequencer for the character buffer write port: cursor, control codes, clear engine.
// Optional CHAR_BUF_AUTOCLEAR_EN: blank the whole buffer automatically when reset is released.
module char_buf_console_ctrl #(
    parameter int          COLS   = 160,
    parameter int          ROWS   = 64,
    parameter int          ADDR_W = 14,
    parameter logic [7:0]  BLANK  = 8'h20
) (
    input  logic              w_clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              clr_req,
    output logic              busy,
    output logic              w,
    output logic [ADDR_W-1:0] w_addr,
    output logic [7:0]        a_in,
    output logic [5:0]        cur_row,
    output logic [7:0]        cur_col
);

    localparam logic [7:0]        COL_LAST = 8'(COLS - 1);
    localparam logic [5:0]        ROW_LAST = 6'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

    typedef enum logic [0:0] {IDLE, CLEAR} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] row_base, row_base_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic [ADDR_W-1:0] w_addr_n;
    logic [7:0]        a_in_n;
    logic [7:0]        col_n;
    logic [5:0]        row_n;
    logic              w_n;
    logic              row_step;
    logic              boot_clr;

`ifdef CHAR_BUF_AUTOCLEAR_EN
    // One-cycle flag after reset that kicks off a clear without a host request.
    always_ff @(posedge w_clk) begin
        boot_clr <= rst;
    end
`else
    assign boot_clr = 1'b0;
`endif

    assign in_ready = (state == IDLE) & ~clr_req & ~boot_clr;
    assign busy     = (state == CLEAR);

    always_comb begin
        state_n    = state;
        row_n      = cur_row;
        col_n      = cur_col;
        row_base_n = row_base;
        cnt_n      = cnt;
        w_n        = 1'b0;
        w_addr_n   = w_addr;
        a_in_n     = a_in;
        row_step   = 1'b0;

        case (state)
            IDLE: begin
                if (clr_req || boot_clr) begin
                    state_n = CLEAR;
                    cnt_n   = '0;
                end else if (in_valid) begin
                    if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                        w_n      = 1'b1;
                        w_addr_n = row_base + ADDR_W'(cur_col);
                        a_in_n   = in_data;
                        if (cur_col == COL_LAST) begin
                            col_n    = '0;
                            row_step = 1'b1;
                        end else begin
                            col_n = cur_col + 8'd1;
                        end
                    end else begin
                        case (in_data)
                            8'h0A: begin
                                col_n    = '0;
                                row_step = 1'b1;
                            end
                            8'h0D: col_n = '0;
                            8'h08: if (cur_col != '0) col_n = cur_col - 8'd1;
                            8'h0C: begin
                                state_n = CLEAR;
                                cnt_n   = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            CLEAR: begin
                w_n      = 1'b1;
                w_addr_n = cnt;
                a_in_n   = BLANK;
                if (cnt == CNT_LAST) begin
                    state_n    = IDLE;
                    row_n      = '0;
                    col_n      = '0;
                    row_base_n = '0;
                end else begin
                    cnt_n = cnt + ONE_A;
                end
            end
            default: state_n = IDLE;
        endcase

        // Row base tracks the row by stepping COLS at a time, so no multiplier is needed.
        if (row_step) begin
            if (cur_row == ROW_LAST) begin
                row_n      = '0;
                row_base_n = '0;
            end else begin
                row_n      = cur_row + 6'd1;
                row_base_n = row_base + COLS_A;
            end
        end
    end

    always_ff @(posedge w_clk) begin
        if (rst) begin
            state    <= IDLE;
            cur_row  <= '0;
            cur_col  <= '0;
            row_base <= '0;
            cnt      <= '0;
            w        <= 1'b0;
            w_addr   <= '0;
            a_in     <= '0;
        end else begin
            state    <= state_n;
            cur_row  <= row_n;
            cur_col  <= col_n;
            row_base <= row_base_n;
            cnt      <= cnt_n;
            w        <= w_n;
            w_addr   <= w_addr_n;
            a_in     <= a_in_n;
        end
    end

endmodule

// File: tb/tb_char_buf_console_ctrl.sv
// Directed bench for char_buf_console_ctrl: text writes, wrap, control codes, clear engine, reset mid-clear.
module tb_char_buf_console_ctrl;

    logic        w_clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        clr_req;
    logic        busy;
    logic        w;
    logic [13:0] w_addr;
    logic [7:0]  a_in;
    logic [5:0]  cur_row;
    logic [7:0]  cur_col;

    int checks   = 0;
    int failures = 0;

    char_buf_console_ctrl #(
        .COLS(160),
        .ROWS(64),
        .ADDR_W(14),
        .BLANK(8'h20)
    ) dut (
        .w_clk(w_clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .clr_req(clr_req),
        .busy(busy),
        .w(w),
        .w_addr(w_addr),
        .a_in(a_in),
        .cur_row(cur_row),
        .cur_col(cur_col)
    );

    initial begin
        w_clk = 1'b0;
        forever #5 w_clk = ~w_clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_wr(input string tag, input int addr, input logic [7:0] data);
        check({tag, "_w"}, w, 1);
        check({tag, "_addr"}, w_addr, addr);
        check({tag, "_data"}, a_in, data);
    endtask

    task automatic check_cur(input string tag, input int row, input int col);
        check({tag, "_row"}, cur_row, row);
        check({tag, "_col"}, cur_col, col);
    endtask

    initial begin
        int bad_wr;
        int bad_busy;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        clr_req  = 1'b0;
        tick();
        tick();
        check("rst_w", w, 0);
        check("rst_addr", w_addr, 0);
        check("rst_data", a_in, 0);
        check_cur("rst_cur", 0, 0);
        check("rst_busy", busy, 0);

        rst = 1'b0;
        tick();
`ifdef CHAR_BUF_AUTOCLEAR_EN
        check("boot_busy", busy, 1);
        repeat (10240) tick();
        check("boot_done", busy, 0);
`else
        check("post_rst_busy", busy, 0);
        check("post_rst_ready", in_ready, 1);
`endif

        // Two printable characters from home
        send(8'h41);
        check_wr("char_A", 0, 8'h41);
        check_cur("after_A", 0, 1);
        send(8'h42);
        check_wr("char_B", 1, 8'h42);
        check_cur("after_B", 0, 2);
        tick();
        check("idle_w", w, 0);

        // CR, BS at column 0, and an unknown code
        send(8'h0D);
        check("cr_w", w, 0);
        check_cur("after_cr", 0, 0);
        send(8'h08);
        check("bs0_w", w, 0);
        check_cur("after_bs0", 0, 0);
        send(8'h01);
        check("unk_w", w, 0);
        check_cur("after_unk", 0, 0);

        // Full row of 'x' wraps to the next row
        for (int i = 0; i < 160; i++) send(8'h78);
        check_wr("row_end", 159, 8'h78);
        check_cur("row_wrap", 1, 0);
        send(8'h79);
        check_wr("row1_first", 160, 8'h79);
        check_cur("after_y", 1, 1);

        // LF moves down and to column 0; reach (5,10) then LF + 'q'
        send(8'h0A);
        check("lf_w", w, 0);
        check_cur("after_lf", 2, 0);
        repeat (3) send(8'h0A);
        for (int i = 0; i < 10; i++) send(8'h63);
        check_wr("row5_c", 809, 8'h63);
        check_cur("at_5_10", 5, 10);
        send(8'h0A);
        check("lf2_w", w, 0);
        check_cur("after_lf2", 6, 0);
        send(8'h71);
        check_wr("char_q", 960, 8'h71);
        check_cur("after_q", 6, 1);
        send(8'h08);
        check("bs_w", w, 0);
        check_cur("after_bs", 6, 0);

        // Last cell of the screen, then wrap to home
        repeat (57) send(8'h0A);
        for (int i = 0; i < 159; i++) send(8'h70);
        check_cur("at_last", 63, 159);
        send(8'h7A);
        check_wr("last_cell", 10239, 8'h7A);
        check_cur("screen_wrap", 0, 0);
        send(8'h6E);
        check_wr("wrap_first", 0, 8'h6E);
        check_cur("after_n", 0, 1);

        // Form feed clears; a clr_req and byte mid-clear are ignored
        send(8'h0C);
        check("ff_busy", busy, 1);
        check("ff_w", w, 0);
        check("ff_ready", in_ready, 0);
        check_cur("ff_cur", 0, 1);
        bad_wr   = 0;
        bad_busy = 0;
        for (int i = 0; i < 10240; i++) begin
            if (i == 100) begin
                clr_req  = 1'b1;
                in_valid = 1'b1;
                in_data  = 8'h72;
                #1;
                check("clr_mid_ready", in_ready, 0);
            end
            tick();
            clr_req  = 1'b0;
            in_valid = 1'b0;
            if (w !== 1'b1 || w_addr !== 14'(i) || a_in !== 8'h20) bad_wr++;
            if (i < 10239 && busy !== 1'b1) bad_busy++;
        end
        check("clear_writes_bad", bad_wr, 0);
        check("clear_busy_bad", bad_busy, 0);
        check("clear_done_busy", busy, 0);
        check_cur("clear_home", 0, 0);
        check("clear_done_ready", in_ready, 1);
        tick();
        check("post_clear_w", w, 0);
        send(8'h6B);
        check_wr("post_clear_k", 0, 8'h6B);
        check_cur("after_k", 0, 1);

        // clr_req and in_valid together: clear wins, byte dropped
        clr_req  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h6D;
        #1;
        check("both_ready", in_ready, 0);
        tick();
        clr_req  = 1'b0;
        in_valid = 1'b0;
        check("both_busy", busy, 1);
        check("both_w", w, 0);
        check_cur("both_cur", 0, 1);
        repeat (10240) tick();
        check("both_done", busy, 0);
        check_cur("both_home", 0, 0);

        // Reset in the middle of a clear
        send(8'h0C);
        repeat (500) tick();
        check_wr("mid_clear", 499, 8'h20);
        rst = 1'b1;
        tick();
        check("midrst_w", w, 0);
        check("midrst_busy", busy, 0);
        check_cur("midrst_cur", 0, 0);
        rst = 1'b0;
        tick();
`ifdef CHAR_BUF_AUTOCLEAR_EN
        check("midrst_reclear", busy, 1);
        tick();
        check_wr("reclear_first", 0, 8'h20);
        repeat (10239) tick();
        check("reclear_done", busy, 0);
`else
        check("midrst_idle", busy, 0);
        send(8'h41);
        check_wr("midrst_A", 0, 8'h41);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
